mp_add_sequencer: RTL
=====================

Name: mp_add_sequencer

Overview:
- Multi-precision add/subtract controller for the team's WIDTH-bit carry-lookahead adder slice.
- Accepts two WORDS*WIDTH-bit operands and time-multiplexes one internal WIDTH-bit slice (with carry-in) over WORDS cycles, least-significant word first, keeping the carry in a register between words.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 4, bits per adder slice (word width).
- WORDS, 4, number of words per operand; total operand width N = WIDTH*WORDS. Legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  N  operand A.
- in_b  input  N  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  N  result, modulo 2^N.
- out_cout  output  1  carry out of the MSB word. For subtract this is the no-borrow flag (1 when A >= B unsigned).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values (async assert, applied immediately): state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, word index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1, latch in_a, in_b and in_sub, and set word index=0.
  - Carry register := in_sub. B is inverted per word when in_sub=1.
  - Go to RUN.
- RUN: each edge processes word i:
  - sum[i] = A[i] + (B[i] ^ {WIDTH{sub}}) + carry.
  - Write sum[i] into out_sum[i*WIDTH +: WIDTH]; carry := slice carry-out; i := i+1.
  - When the edge processing word WORDS-1 occurs, out_cout := that carry-out and go to DONE.
- DONE: out_valid=1, and out_sum/out_cout are held stable.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - out_sum and out_cout keep their last values, but are only meaningful while out_valid=1.
- Latency: request accepted at edge T; out_valid rises after edge T+WORDS. Best-case throughput is one operation per WORDS+2 cycles.
- in_ready=0 in RUN and DONE. in_valid there is ignored and does not corrupt the operation. No accept occurs in the same cycle as a result handshake.
- Operands are sampled only at accept. Input changes after accept have no effect.
- Arithmetic:
  - Results wrap modulo 2^N.
  - The carry chain crosses every word boundary through the carry register; a carry produced by the MSB word goes only to out_cout.
  - Subtract is two's complement (invert B, carry-in 1).
- Backpressure: DONE is held indefinitely while out_ready=0.
- out_ready asserted outside DONE is ignored.
- Reset asserted mid-RUN or in DONE: immediately abort to reset values; the partial result is discarded. The first request after reset release is accepted normally.
- Word index counter is width clog2(WORDS). It never exceeds WORDS-1.

Test Plan (WIDTH=4, WORDS=4, N=16):
- Basic add: A=0x1234, B=0x4321, sub=0 → out_valid exactly 4 cycles after the accept edge; out_sum=0x5555, out_cout=0.
- Full carry ripple: A=0xFFFF, B=0x0001 → out_sum=0x0000, out_cout=1. Check the carry register is 1 after each of words 0–2.
- Subtract with borrow: A=0x0000, B=0x0001, sub=1 → out_sum=0xFFFF, out_cout=0.
- Subtract without borrow: A=0x8000, B=0x7FFF, sub=1 → out_sum=0x0001, out_cout=1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles after out_valid; out_sum stays stable and in_ready stays 0.
  - Toggle in_valid and operands during RUN; the result is unaffected.
  - Raise out_ready; the next cycle is IDLE and in_ready=1.
- Reset mid-operation: assert rst after word 1 of A=0xAAAA+B=0x5555.
  - Outputs go to reset values immediately.
  - After release, 0x0F0F+0x00F1 gives 0x1000, out_cout=0.

Source files
------------

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit carry-lookahead slice
// is reused over WORDS cycles, least-significant word first.

module mp_add_cla_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic             run;

  // Every carry is a flat sum-of-products of generate/propagate terms and cin,
  // so no carry depends on a lower carry bit.
  always_comb begin
    gen   = a & b;
    prop  = a ^ b;
    carry = '0;
    run   = 1'b0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i];
      run = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry[i+1] = carry[i+1] | (run & gen[j]);
        run = run & prop[j];
      end
      carry[i+1] = carry[i+1] | (run & cin);
    end
    sum  = prop ^ carry[WIDTH-1:0];
    cout = carry[WIDTH];
  end

endmodule

module mp_add_sequencer #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [N-1:0]      a_q;
  logic [N-1:0]      b_q;
  logic              sub_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [N-1:0]      sum_q;
  logic              cout_q;

  logic [WIDTH-1:0]  word_a;
  logic [WIDTH-1:0]  word_b;
  logic [WIDTH-1:0]  word_b_eff;
  logic [WIDTH-1:0]  slice_sum;
  logic              slice_cout;
  logic              last_word;

  assign last_word = (idx_q == IDXW'(WORDS - 1));

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDXW'(w)) begin
        word_a = a_q[w*WIDTH +: WIDTH];
        word_b = b_q[w*WIDTH +: WIDTH];
      end
    end
    word_b_eff = word_b ^ {WIDTH{sub_q}};
  end

  mp_add_cla_slice #(
    .WIDTH(WIDTH)
  ) u_slice (
    .a    (word_a),
    .b    (word_b_eff),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_word) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The MSB word's carry only feeds out_cout; the carry register keeps the
  // word 2 carry so it never leaks into a later operation's chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            sub_q   <= in_sub;
            carry_q <= in_sub;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDXW'(w)) begin
              sum_q[w*WIDTH +: WIDTH] <= slice_sum;
            end
          end
          if (last_word) begin
            cout_q <= slice_cout;
            idx_q  <= '0;
          end else begin
            carry_q <= slice_cout;
            idx_q   <= idx_q + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule
